// File: rtl/qpi_line_burst_master.sv
// Cache-line burst sequencer feeding the QPI/SDRAM adapter's held-strobe burst port.
// One request is serviced at a time: IDLE accepts it, BURST counts beats, DRAIN waits for the adapter.
module qpi_line_burst_master #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_STEP  = 2,
    localparam int CW        = $clog2(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    output logic          req_ready,
    output logic [CW-1:0] line_idx,
    input  logic [DW-1:0] line_wdata,
    output logic          line_rvalid,
    output logic [DW-1:0] line_rdata,
    output logic          done,
    output logic          err_align,
    output logic          qpi_do_read,
    output logic          qpi_do_write,
    output logic [AW-1:0] qpi_addr,
    output logic [DW-1:0] qpi_wdata,
    input  logic [DW-1:0] qpi_rdata,
    input  logic          qpi_next_word,
    input  logic          qpi_is_idle
);
    localparam int LINE_SPAN = LINE_WORDS * ADDR_STEP;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic          last, busy_req, accept, misaligned;

    assign last       = (cnt == CW'(LINE_WORDS - 1));
    assign misaligned = (req_addr % AW'(LINE_SPAN)) != '0;
    assign accept     = (state == IDLE) && req_valid && req_ready;

    // Data paths are pure wires; the adapter and line buffer own the timing.
    assign line_idx   = (state == BURST) ? cnt : '0;
    assign line_rdata = qpi_rdata;
    assign qpi_wdata  = line_wdata;
    assign qpi_addr   = addr_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            we_r      <= 1'b0;
            addr_r    <= '0;
            err_align <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_r   <= req_we;
                addr_r <= req_addr;
                if (misaligned)
                    err_align <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        req_ready    = 1'b0;
        qpi_do_read  = 1'b0;
        qpi_do_write = 1'b0;
        line_rvalid  = 1'b0;
        done         = 1'b0;
        busy_req     = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so the handshake stays quiet while held in reset.
                req_ready = qpi_is_idle && rst;
                if (req_valid && req_ready) begin
                    state_nxt = BURST;
                    cnt_nxt   = '0;
                end
            end
            BURST: begin
                // Strobe must drop in the same cycle as the final beat so the
                // adapter ends the burst on that edge instead of starting another word.
                busy_req     = !(qpi_next_word && last);
                qpi_do_read  = !we_r && busy_req;
                qpi_do_write = we_r && busy_req;
                if (qpi_next_word) begin
                    line_rvalid = !we_r;
                    cnt_nxt     = cnt + CW'(1);
                    if (last)
                        state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (qpi_is_idle) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/qpi_line_burst_master.md
Name: qpi_line_burst_master

Overview:
- Cache-side burst sequencer that sits directly upstream of the QPI-to-SDRAM Wishbone adapter.
- Accepts one cache-line refill or writeback request and drives the adapter's held qpi_do_read/qpi_do_write burst interface.
- Counts qpi_next_word beats and delivers or fetches line words by index.
- Releases the request strobe exactly on the last beat, so the adapter terminates its burst cleanly.

Parameters:
AW, 24, address width (adapter address units; one DW word spans ADDR_STEP units)
DW, 32, data word width
LINE_WORDS, 8, words per line; power of two, 2..64
ADDR_STEP, 2, address units per word; used only for the alignment check

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  line request pending; held until accepted
req_we  in  1  1 = writeback, 0 = refill
req_addr  in  AW  line base address; must be aligned to LINE_WORDS*ADDR_STEP
req_ready  out  1  request accepted this cycle when req_valid & req_ready
line_idx  out  log2(LINE_WORDS)  current beat index (write fetch index and read write-back index)
line_wdata  in  DW  writeback word for line_idx, combinational from the line buffer
line_rvalid  out  1  one-cycle strobe: line_rdata is the word for line_idx
line_rdata  out  DW  refill word
done  out  1  one-cycle pulse; burst complete and adapter idle
err_align  out  1  sticky flag for a misaligned request; cleared by reset only
qpi_do_read  out  1  to adapter
qpi_do_write  out  1  to adapter
qpi_addr  out  AW  to adapter
qpi_wdata  out  DW  to adapter
qpi_rdata  in  DW  from adapter
qpi_next_word  in  1  from adapter, one-cycle beat strobe
qpi_is_idle  in  1  from adapter

Behaviour:
- Reset (rst low, asynchronous): state IDLE, beat counter 0.
  - All outputs 0: req_ready, line_rvalid, done, qpi_do_read, qpi_do_write, qpi_addr, err_align.
  - Release of reset is synchronous to clk.
- States:
  - IDLE: req_ready = qpi_is_idle. On req_valid & req_ready:
    - latch req_we into we_r and req_addr into addr_r;
    - clear the beat counter;
    - go to BURST.
    - If req_addr is misaligned, set err_align and still run the burst at the given address.
  - BURST: qpi_do_read = ~we_r & busy_req; qpi_do_write = we_r & busy_req; qpi_addr = addr_r (held constant for the whole burst).
    - busy_req = ~(qpi_next_word & last), where last = (counter == LINE_WORDS-1).
    - The deassertion is combinational, in the same cycle as the last qpi_next_word. This is mandatory: the adapter samples the strobe on that edge to decide whether to continue.
  - Each qpi_next_word in BURST:
    - if ~we_r, assert line_rvalid with line_rdata = qpi_rdata and line_idx = counter, same cycle;
    - increment the counter;
    - if last, go to DRAIN.
  - Write data: qpi_wdata = line_wdata, with line_idx = counter. The word must be valid whenever in BURST, because the adapter may sample it on any cycle of a beat.
  - DRAIN: qpi_do_* = 0. Wait for qpi_is_idle = 1, then pulse done for 1 cycle and go to IDLE.
    - DRAIN lasts at least 1 cycle, covering the adapter's end-of-beat state.
- Latency: req accept -> qpi_do_* high on the next cycle.
- Boundary conditions:
  - qpi_next_word outside BURST is ignored and counted nowhere.
  - req_valid while busy: req_ready stays 0 and the request is held off.
  - req_valid in IDLE while qpi_is_idle = 0: not accepted until the adapter is idle.
  - LINE_WORDS = 2: last is asserted on beat 1.
  - Counter width is log2(LINE_WORDS). It wraps to 0 on the last beat.
  - Reset mid-burst drops qpi_do_* immediately; the adapter's own reset is expected to accompany it.
  - line_idx holds at 0 in IDLE and DRAIN.

Test Plan:
- Refill at addr 0x000100, LINE_WORDS=8, adapter model stall-free returning 0xA0..0xA7 -> 8 line_rvalid pulses with idx 0..7 and data 0xA0..0xA7. qpi_do_read falls in the same cycle as the 8th qpi_next_word. One done pulse. Adapter sees exactly 8 beats, last at 0x00010E.
- Writeback at 0x000200, line buffer words 0x55000000+i -> adapter writes 8 words, qpi_wdata equal to line buffer word i on beat i, qpi_do_write low on the last beat, done pulse, no line_rvalid.
- Random i_wb_stall/ack latency (1..6 cycles) in the adapter -> beat count, idx order and data unchanged; done only after qpi_is_idle.
- Back-to-back requests, second req_valid held during the first burst -> req_ready 0 until done of the first. Second burst starts only after qpi_is_idle, with a fresh counter.
- Misaligned req_addr 0x000104 -> err_align set and sticky, burst still completes 8 beats; stray qpi_next_word in IDLE -> no line_rvalid, counter unchanged.
- rst low during beat 3 of a refill -> all outputs 0 asynchronously. After release, a new request completes normally from idx 0.
